scan_capture: RTL and testbench
===============================

SCAN_CAPTURE -- requirements
Module: scan_capture

Interface
REQ-001 The block SHALL have parameter STABLE, default 2, meaning consecutive identical synchronized samples (1..15) required to accept a phase.
REQ-002 The block SHALL have port clk  input  1  clock.
REQ-003 The block SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 The block SHALL have port Ein  input  4  scanned digit enable, active-low, one-hot-low.
REQ-005 The block SHALL have port Din  input  4  scanned digit value.
REQ-006 The block SHALL have port err_clr  input  1  synchronous clear of err.
REQ-007 The block SHALL have ports Q0, Q1, Q2, Q3  output  4 each  captured digits of the last complete frame.
REQ-008 The block SHALL have port frame_done  output  1  one-cycle pulse per completed frame.
REQ-009 The block SHALL have port err  output  1  sticky error flag.
REQ-010 The block SHALL have port cur_idx  output  2  index of the last accepted digit.

Function
REQ-011 Ein and Din SHALL pass through a 2-flop synchronizer; all decoding uses the synchronized values.
REQ-012 A stability counter SHALL count cycles the synchronized {Ein,Din} is unchanged; any change reloads it to 1; the counter saturates at STABLE.
REQ-013 A phase SHALL be accepted exactly once, on the edge where the counter reaches STABLE; no re-acceptance until {Ein,Din} changes.
REQ-014 Ein decode: 0111->idx0, 1011->idx1, 1101->idx2, 1110->idx3; 1111 = blank, ignored, no error; any other value = illegal.
REQ-015 Sequence FSM states: IDLE (expect idx0) and TRACK(exp=1..3).
REQ-016 IDLE: accepted idx0 -> write shadow[0], go TRACK exp=1; any other accepted idx -> stay IDLE, no error (mid-frame start).
REQ-017 TRACK: accepted idx==exp -> write shadow[exp], exp+1; idx3 accepted with exp==3 -> copy shadow[0..2] and Din to Q0..Q3 on that edge, pulse frame_done next cycle, go IDLE.
REQ-018 TRACK: accepted idx!=exp -> set err; if idx==0 write shadow[0] and restart at exp=1, else go IDLE.
REQ-019 Accepted illegal Ein -> set err, go IDLE, shadow unchanged.
REQ-020 Q0..Q3 SHALL change only on frame completion; partial frames never reach Q.
REQ-021 Latency: input stable from edge n -> Q updated at edge n+2+STABLE when that phase completes a frame.
REQ-022 err SHALL stay 1 until err_clr=1; err_clr and a new error on the same edge -> err stays 1.
REQ-023 cur_idx SHALL update on every accepted legal phase.

Reset
REQ-024 rst=0 SHALL immediately force Q0..Q3=0, frame_done=0, err=0, cur_idx=0, FSM=IDLE, shadow=0, sync Ein regs=4'b1111, sync Din regs=0, counter=0.
REQ-025 Reset mid-frame SHALL discard the partial frame; after release the first complete frame starts at idx0.

Structure
REQ-026 A shared package scan_pkg SHALL hold the enable-pattern constants (EN0=0111, EN1=1011, EN2=1101, EN3=1110, BLANK=1111), the FSM state typedef, and the index width.
REQ-027 One sub-module scan_sync (parameterized-width 2-flop synchronizer with reset value input) SHALL be used for Ein and Din.

Verification
REQ-028 Phases held 4 cycles each: (0111,3),(1011,7),(1101,A),(1110,F) -> Q0..Q3=3,7,A,F, frame_done single pulse at edge n+2+STABLE of last phase, err=0.
REQ-029 Each phase held 1 cycle with STABLE=2 -> no acceptance, Q unchanged, frame_done never asserted.
REQ-030 Sequence idx0,idx2 -> err=1, FSM IDLE; then full ordered frame (1,2,3,4) -> Q=1,2,3,4, err stays 1 until err_clr pulse, then 0.
REQ-031 Ein=0011 held 4 cycles mid-frame -> err=1, partial frame discarded, Q keeps prior values; blank 1111 between phases -> no error, frame completes.
REQ-032 Assert rst after idx0,idx1 accepted -> all outputs 0 immediately; after release, idx2,idx3 alone -> no frame_done; full frame then completes normally.

Source files
------------

// File: rtl/scan_pkg.sv
// Shared definitions for the scanned-display capture block: enable patterns,
// sequencer state type and the enable decoder.
package scan_pkg;

    localparam int IDX_W = 2;

    localparam logic [3:0] EN0   = 4'b0111;
    localparam logic [3:0] EN1   = 4'b1011;
    localparam logic [3:0] EN2   = 4'b1101;
    localparam logic [3:0] EN3   = 4'b1110;
    localparam logic [3:0] BLANK = 4'b1111;

    typedef enum logic {
        IDLE,
        TRACK
    } state_t;

    typedef struct packed {
        logic             legal;
        logic             blank;
        logic [IDX_W-1:0] idx;
    } dec_t;

    // Maps an active-low one-hot enable to a digit index.
    // A value that is neither legal nor blank is illegal.
    function automatic dec_t decode_en(input logic [3:0] en);
        dec_t d;
        d.legal = 1'b0;
        d.blank = 1'b0;
        d.idx   = '0;
        case (en)
            EN0:     begin d.legal = 1'b1; d.idx = 2'd0; end
            EN1:     begin d.legal = 1'b1; d.idx = 2'd1; end
            EN2:     begin d.legal = 1'b1; d.idx = 2'd2; end
            EN3:     begin d.legal = 1'b1; d.idx = 2'd3; end
            BLANK:   d.blank = 1'b1;
            default: ;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/scan_sync.sv
// Two-flop synchronizer of configurable width; both stages load 'init' on reset.
module scan_sync #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] init,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta <= init;
            q    <= init;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/scan_capture.sv
// Captures one four-digit frame from a multiplexed (scanned) display bus,
// filtering glitches and checking the digit scan order.
module scan_capture
    import scan_pkg::*;
#(
    parameter int STABLE = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [3:0]           Ein,
    input  logic [3:0]           Din,
    input  logic                 err_clr,
    output logic [3:0]           Q0,
    output logic [3:0]           Q1,
    output logic [3:0]           Q2,
    output logic [3:0]           Q3,
    output logic                 frame_done,
    output logic                 err,
    output logic [IDX_W-1:0]     cur_idx
);

    localparam logic [3:0] STABLE_C = 4'(STABLE);

    logic [3:0]       ein_s, din_s;
    logic [3:0]       ein_l, din_l;
    logic [3:0]       cnt, cnt_n;
    logic             change, reach, acc;

    state_t           state, state_n;
    logic [IDX_W-1:0] exp_idx, exp_n;
    logic [3:0]       sh0, sh1, sh2;
    logic [2:0]       sh_we;
    logic             load_q, set_err, upd_idx;
    dec_t             dec;

    scan_sync #(.W(4)) u_sync_en (
        .clk  (clk),
        .rst  (rst),
        .init (BLANK),
        .d    (Ein),
        .q    (ein_s)
    );

    scan_sync #(.W(4)) u_sync_din (
        .clk  (clk),
        .rst  (rst),
        .init (4'h0),
        .d    (Din),
        .q    (din_s)
    );

    // Reaching STABLE from below (or on a reload when STABLE is 1) is the one
    // and only acceptance of a phase; a saturated counter never re-fires.
    always_comb begin
        change = (ein_s != ein_l) || (din_s != din_l);
        cnt_n  = cnt;
        if (change)
            cnt_n = 4'd1;
        else if (cnt < STABLE_C)
            cnt_n = cnt + 4'd1;
        reach = (cnt_n == STABLE_C) && (change || (cnt != STABLE_C));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ein_l <= BLANK;
            din_l <= 4'h0;
            cnt   <= 4'd0;
            acc   <= 1'b0;
        end else begin
            ein_l <= ein_s;
            din_l <= din_s;
            cnt   <= cnt_n;
            acc   <= reach;
        end
    end

    // The accepted phase is still held in ein_l/din_l on the cycle after acc.
    always_comb begin
        dec     = decode_en(ein_l);
        state_n = state;
        exp_n   = exp_idx;
        sh_we   = 3'b000;
        load_q  = 1'b0;
        set_err = 1'b0;
        upd_idx = 1'b0;
        if (acc && !dec.blank) begin
            if (!dec.legal) begin
                set_err = 1'b1;
                state_n = IDLE;
                exp_n   = 2'd1;
            end else begin
                upd_idx = 1'b1;
                unique case (state)
                    IDLE: begin
                        if (dec.idx == 2'd0) begin
                            sh_we[0] = 1'b1;
                            state_n  = TRACK;
                            exp_n    = 2'd1;
                        end
                    end
                    TRACK: begin
                        if (dec.idx == exp_idx) begin
                            if (exp_idx == 2'd3) begin
                                load_q  = 1'b1;
                                state_n = IDLE;
                                exp_n   = 2'd1;
                            end else begin
                                sh_we[exp_idx] = 1'b1;
                                exp_n          = exp_idx + 2'd1;
                            end
                        end else begin
                            set_err = 1'b1;
                            if (dec.idx == 2'd0) begin
                                sh_we[0] = 1'b1;
                                exp_n    = 2'd1;
                            end else begin
                                state_n = IDLE;
                                exp_n   = 2'd1;
                            end
                        end
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            exp_idx    <= 2'd1;
            sh0        <= 4'h0;
            sh1        <= 4'h0;
            sh2        <= 4'h0;
            Q0         <= 4'h0;
            Q1         <= 4'h0;
            Q2         <= 4'h0;
            Q3         <= 4'h0;
            frame_done <= 1'b0;
            err        <= 1'b0;
            cur_idx    <= '0;
        end else begin
            state      <= state_n;
            exp_idx    <= exp_n;
            frame_done <= load_q;
            if (sh_we[0]) sh0 <= din_l;
            if (sh_we[1]) sh1 <= din_l;
            if (sh_we[2]) sh2 <= din_l;
            if (load_q) begin
                Q0 <= sh0;
                Q1 <= sh1;
                Q2 <= sh2;
                Q3 <= din_l;
            end
            // A new error outranks a clear on the same edge.
            if (set_err)
                err <= 1'b1;
            else if (err_clr)
                err <= 1'b0;
            if (upd_idx)
                cur_idx <= dec.idx;
        end
    end

endmodule

// File: tb/tb_scan_capture.sv
// Directed self-checking bench for scan_capture with the default STABLE of 2.
module tb_scan_capture;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] Ein, Din;
    logic       err_clr;
    logic [3:0] Q0, Q1, Q2, Q3;
    logic       frame_done, err;
    logic [1:0] cur_idx;

    int tests = 0;
    int fails = 0;
    int fd_count = 0;

    scan_capture dut (
        .clk        (clk),
        .rst        (rst),
        .Ein        (Ein),
        .Din        (Din),
        .err_clr    (err_clr),
        .Q0         (Q0),
        .Q1         (Q1),
        .Q2         (Q2),
        .Q3         (Q3),
        .frame_done (frame_done),
        .err        (err),
        .cur_idx    (cur_idx)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (frame_done === 1'b1) fd_count++;
    end

    task automatic apply_stimulus(input logic [3:0] e, input logic [3:0] d, input int n);
        Ein = e;
        Din = d;
        repeat (n) @(negedge clk);
    endtask

    task automatic check_output(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        tests++;
        assert (obs === expv)
        else begin
            fails++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic pulse_clear();
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
    endtask

    initial begin
        rst     = 1'b0;
        Ein     = 4'b1111;
        Din     = 4'h0;
        err_clr = 1'b0;
        repeat (3) @(negedge clk);
        check_output("reset_q", {Q0, Q1, Q2, Q3}, 16'h0000);
        check_output("reset_flags", {13'd0, frame_done, err, 1'b0}, 16'h0000);
        check_output("reset_idx", {14'd0, cur_idx}, 16'h0000);
        rst = 1'b1;
        apply_stimulus(4'b1111, 4'h0, 6);

        // Ordered frame, 4 cycles per phase, with exact completion latency
        apply_stimulus(4'b0111, 4'h3, 4);
        apply_stimulus(4'b1011, 4'h7, 4);
        apply_stimulus(4'b1101, 4'hA, 4);
        apply_stimulus(4'b1110, 4'hF, 4);
        check_output("frame1_fd_early", {15'd0, frame_done}, 16'h0000);
        check_output("frame1_q_early", {Q0, Q1, Q2, Q3}, 16'h0000);
        @(negedge clk);
        check_output("frame1_fd_pulse", {15'd0, frame_done}, 16'h0001);
        check_output("frame1_q", {Q0, Q1, Q2, Q3}, 16'h37AF);
        @(negedge clk);
        check_output("frame1_fd_low", {15'd0, frame_done}, 16'h0000);
        repeat (4) @(negedge clk);
        check_output("frame1_fd_count", 16'(fd_count), 16'd1);
        check_output("frame1_err", {15'd0, err}, 16'h0000);
        check_output("frame1_idx", {14'd0, cur_idx}, 16'h0003);

        // One-cycle phases never pass the stability filter
        apply_stimulus(4'b0111, 4'h1, 1);
        apply_stimulus(4'b1011, 4'h2, 1);
        apply_stimulus(4'b1101, 4'h3, 1);
        apply_stimulus(4'b1110, 4'h4, 1);
        apply_stimulus(4'b1111, 4'h0, 8);
        check_output("glitch_q", {Q0, Q1, Q2, Q3}, 16'h37AF);
        check_output("glitch_fd_count", 16'(fd_count), 16'd1);
        check_output("glitch_idx", {14'd0, cur_idx}, 16'h0003);

        // Out-of-order idx0,idx2 sets err; a clean frame still completes
        apply_stimulus(4'b0111, 4'h1, 4);
        apply_stimulus(4'b1101, 4'h9, 4);
        apply_stimulus(4'b1111, 4'h0, 4);
        check_output("order_err", {15'd0, err}, 16'h0001);
        check_output("order_idx", {14'd0, cur_idx}, 16'h0002);
        apply_stimulus(4'b0111, 4'h1, 4);
        apply_stimulus(4'b1011, 4'h2, 4);
        apply_stimulus(4'b1101, 4'h3, 4);
        apply_stimulus(4'b1110, 4'h4, 4);
        apply_stimulus(4'b1111, 4'h0, 4);
        check_output("order_q", {Q0, Q1, Q2, Q3}, 16'h1234);
        check_output("order_err_sticky", {15'd0, err}, 16'h0001);
        check_output("order_fd_count", 16'(fd_count), 16'd2);
        pulse_clear();
        check_output("order_err_cleared", {15'd0, err}, 16'h0000);

        // Illegal enable mid-frame discards the partial frame
        apply_stimulus(4'b0111, 4'h5, 4);
        apply_stimulus(4'b1011, 4'h6, 4);
        apply_stimulus(4'b0011, 4'h0, 4);
        apply_stimulus(4'b1101, 4'h7, 4);
        apply_stimulus(4'b1110, 4'h8, 4);
        apply_stimulus(4'b1111, 4'h0, 4);
        check_output("illegal_err", {15'd0, err}, 16'h0001);
        check_output("illegal_q", {Q0, Q1, Q2, Q3}, 16'h1234);
        check_output("illegal_fd_count", 16'(fd_count), 16'd2);
        pulse_clear();

        // Blank phases between digits are harmless
        apply_stimulus(4'b0111, 4'h9, 4);
        apply_stimulus(4'b1111, 4'h0, 4);
        apply_stimulus(4'b1011, 4'hA, 4);
        apply_stimulus(4'b1111, 4'h0, 4);
        apply_stimulus(4'b1101, 4'hB, 4);
        apply_stimulus(4'b1111, 4'h0, 4);
        apply_stimulus(4'b1110, 4'hC, 4);
        apply_stimulus(4'b1111, 4'h0, 4);
        check_output("blank_q", {Q0, Q1, Q2, Q3}, 16'h9ABC);
        check_output("blank_err", {15'd0, err}, 16'h0000);
        check_output("blank_fd_count", 16'(fd_count), 16'd3);

        // Reset mid-frame clears everything at once
        apply_stimulus(4'b0011, 4'h0, 4);
        apply_stimulus(4'b0111, 4'hD, 4);
        apply_stimulus(4'b1011, 4'hE, 4);
        apply_stimulus(4'b1111, 4'h0, 4);
        check_output("pre_reset_idx", {14'd0, cur_idx}, 16'h0001);
        check_output("pre_reset_err", {15'd0, err}, 16'h0001);
        rst = 1'b0;
        #1;
        check_output("async_reset_q", {Q0, Q1, Q2, Q3}, 16'h0000);
        check_output("async_reset_flags", {13'd0, frame_done, err, 1'b0}, 16'h0000);
        check_output("async_reset_idx", {14'd0, cur_idx}, 16'h0000);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        apply_stimulus(4'b1111, 4'h0, 4);
        apply_stimulus(4'b1101, 4'h1, 4);
        apply_stimulus(4'b1110, 4'h2, 4);
        apply_stimulus(4'b1111, 4'h0, 4);
        check_output("post_reset_partial_fd", 16'(fd_count), 16'd3);
        check_output("post_reset_partial_q", {Q0, Q1, Q2, Q3}, 16'h0000);
        apply_stimulus(4'b0111, 4'h5, 4);
        apply_stimulus(4'b1011, 4'h6, 4);
        apply_stimulus(4'b1101, 4'h7, 4);
        apply_stimulus(4'b1110, 4'h8, 4);
        apply_stimulus(4'b1111, 4'h0, 4);
        check_output("post_reset_q", {Q0, Q1, Q2, Q3}, 16'h5678);
        check_output("post_reset_fd_count", 16'(fd_count), 16'd4);
        check_output("post_reset_err", {15'd0, err}, 16'h0000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
